// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// One operation is in flight at a time: a request is granted in IDLE,
// its operands drive the ALU for one cycle (or MUL_CYCLES for a multiply),
// and the result is held for the owning requester until it is consumed.
module alu_arbiter #(
   parameter int unsigned MUL_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req0_valid_i,
   output logic        req0_ready_o,
   input  logic [2:0]  req0_ctrl_i,
   input  logic [31:0] req0_data1_i,
   input  logic [31:0] req0_data2_i,
   input  logic        req1_valid_i,
   output logic        req1_ready_o,
   input  logic [2:0]  req1_ctrl_i,
   input  logic [31:0] req1_data1_i,
   input  logic [31:0] req1_data2_i,
   output logic        resp0_valid_o,
   input  logic        resp0_ready_i,
   output logic [31:0] resp0_data_o,
   output logic        resp1_valid_o,
   input  logic        resp1_ready_i,
   output logic [31:0] resp1_data_o,
   output logic [31:0] alu_data1_o,
   output logic [31:0] alu_data2_o,
   output logic [2:0]  alu_ctrl_o,
   input  logic [31:0] alu_data_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [2:0] CTRL_MUL = 3'b101;
   localparam logic [3:0] MUL_CNT  = 4'(MUL_CYCLES);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        last_grant_q, last_grant_d;
   logic        gid_q, gid_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] data1_q, data1_d;
   logic [31:0] data2_q, data2_d;
   logic [31:0] result_q, result_d;

   logic        grant;
   logic        any_valid;
   logic        transfer;
   logic        resp_ready;
   logic [2:0]  sel_ctrl;

   // Round-robin grant: a lone requester wins, on contention the one not served last wins.
   always_comb begin
      grant = ~last_grant_q;
      if (req0_valid_i && !req1_valid_i) begin
         grant = 1'b0;
      end else if (req1_valid_i && !req0_valid_i) begin
         grant = 1'b1;
      end
      any_valid    = req0_valid_i | req1_valid_i;
      req0_ready_o = (state_q == IDLE) && any_valid && !grant;
      req1_ready_o = (state_q == IDLE) && any_valid &&  grant;
      transfer     = (req0_valid_i && req0_ready_o) || (req1_valid_i && req1_ready_o);
      sel_ctrl     = grant ? req1_ctrl_i : req0_ctrl_i;
      resp_ready   = gid_q ? resp1_ready_i : resp0_ready_i;
   end

   // Next-state and register-update logic for the operation sequencer.
   always_comb begin
      // NOTE: every _d starts as its _q so that no path through the case leaves a
      // signal unassigned, which would otherwise infer a latch.
      state_d      = state_q;
      cnt_d        = cnt_q;
      last_grant_d = last_grant_q;
      gid_d        = gid_q;
      ctrl_d       = ctrl_q;
      data1_d      = data1_q;
      data2_d      = data2_q;
      result_d     = result_q;
      case (state_q)
         IDLE: begin
            if (transfer) begin
               state_d      = EXEC;
               gid_d        = grant;
               last_grant_d = grant;
               ctrl_d       = sel_ctrl;
               data1_d      = grant ? req1_data1_i : req0_data1_i;
               data2_d      = grant ? req1_data2_i : req0_data2_i;
               cnt_d        = (sel_ctrl == CTRL_MUL) ? MUL_CNT : 4'd1;
            end
         end
         EXEC: begin
            if (cnt_q <= 4'd1) begin
               result_d = alu_data_i;
               cnt_d    = 4'd0;
               state_d  = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         last_grant_q <= 1'b1;
         gid_q        <= 1'b0;
         ctrl_q       <= 3'd0;
         data1_q      <= 32'd0;
         data2_q      <= 32'd0;
         result_q     <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         last_grant_q <= last_grant_d;
         gid_q        <= gid_d;
         ctrl_q       <= ctrl_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         result_q     <= result_d;
      end
   end

   // Operand registers only change on a transfer, so the ALU drive holds its last value outside EXEC.
   assign alu_data1_o   = data1_q;
   assign alu_data2_o   = data2_q;
   assign alu_ctrl_o    = ctrl_q;
   assign resp0_valid_o = (state_q == RESP) && !gid_q;
   assign resp1_valid_o = (state_q == RESP) &&  gid_q;
   assign resp0_data_o  = result_q;
   assign resp1_data_o  = result_q;
   assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter with a behavioural ALU attached.
module tb_alu_arbiter;

   localparam int unsigned MUL_CYCLES = 3;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        req0_valid_i, req1_valid_i;
   logic        req0_ready_o, req1_ready_o;
   logic [2:0]  req0_ctrl_i, req1_ctrl_i;
   logic [31:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
   logic        resp0_valid_o, resp1_valid_o;
   logic        resp0_ready_i, resp1_ready_i;
   logic [31:0] resp0_data_o, resp1_data_o;
   logic [31:0] alu_data1_o, alu_data2_o, alu_data_i;
   logic [2:0]  alu_ctrl_o;
   logic        busy_o;

   typedef struct {
      logic        id;
      logic [31:0] data;
   } exp_t;

   exp_t sb_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   alu_arbiter #(.MUL_CYCLES(MUL_CYCLES)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_ctrl_i(req0_ctrl_i),
      .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
      .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_ctrl_i(req1_ctrl_i),
      .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
      .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
      .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
      .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o), .alu_ctrl_o(alu_ctrl_o),
      .alu_data_i(alu_data_i), .busy_o(busy_o)
   );

   // Shared ALU model: 000 and, 001 or, 010 xor, 011 add, 100 sub, 101 mul, 110 sll, 111 sra.
   function automatic logic [31:0] alu_model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      case (c)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a ^ b;
         3'b011:  return a + b;
         3'b100:  return a - b;
         3'b101:  return a * b;
         3'b110:  return a << b[4:0];
         default: return 32'($signed(a) >>> b[4:0]);
      endcase
   endfunction

   always_comb alu_data_i = alu_model(alu_ctrl_o, alu_data1_o, alu_data2_o);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic score(input logic id, input logic [31:0] data);
      exp_t e;
      if (sb_q.size() == 0) begin
         check("resp_unexpected", 32'(id) + 32'd1, 32'd0);
      end else begin
         e = sb_q.pop_front();
         check("resp_id", 32'(id), 32'(e.id));
         check("resp_data", data, e.data);
      end
   endtask

   // Response monitor: every consumed response is matched against the scoreboard.
   always @(negedge clk_i) begin
      if (!rst_i) begin
         if (resp0_valid_o && resp0_ready_i) score(1'b0, resp0_data_o);
         if (resp1_valid_o && resp1_ready_i) score(1'b1, resp1_data_o);
      end
   end

   task automatic do_reset();
      rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
   endtask

   task automatic set_req(input logic id, input logic v, input logic [2:0] c,
                          input logic [31:0] a, input logic [31:0] b);
      if (id) begin
         req1_valid_i = v; req1_ctrl_i = c; req1_data1_i = a; req1_data2_i = b;
      end else begin
         req0_valid_i = v; req0_ctrl_i = c; req0_data1_i = a; req0_data2_i = b;
      end
   endtask

   // Presents one request, waits for its grant, and returns just after the transfer edge.
   task automatic issue(input logic id, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input bit expect_resp);
      bit seen = 1'b0;
      @(posedge clk_i);
      #1 set_req(id, 1'b1, c, a, b);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         if (id ? req1_ready_o : req0_ready_o) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         check("req_ready_timeout", 32'd0, 32'd1);
         set_req(id, 1'b0, c, a, b);
      end else begin
         @(posedge clk_i);
         if (expect_resp) sb_q.push_back('{id: id, data: alu_model(c, a, b)});
         #1 set_req(id, 1'b0, c, a, b);
      end
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_i);
         if (!busy_o) break;
      end
      check("idle_timeout", 32'(busy_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      bit seen;
      rst_i = 1'b1;
      resp0_ready_i = 1'b0;
      resp1_ready_i = 1'b0;
      set_req(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
      set_req(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
      do_reset();

      // Reset state
      @(negedge clk_i);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
      check("rst_resp_valid", {30'd0, resp1_valid_o, resp0_valid_o}, 32'd0);
      check("rst_alu_data1", alu_data1_o, 32'd0);
      check("rst_alu_data2", alu_data2_o, 32'd0);
      check("rst_alu_ctrl", 32'(alu_ctrl_o), 32'd0);
      check("rst_resp0_data", resp0_data_o, 32'd0);
      check("rst_resp1_data", resp1_data_o, 32'd0);

      // Single add: EXEC at T+1, RESP at T+2, IDLE at T+3
      resp0_ready_i = 1'b1;
      resp1_ready_i = 1'b1;
      issue(1'b0, 3'b011, 32'd5, 32'd7, 1'b1);
      @(negedge clk_i);
      check("add_alu_data1", alu_data1_o, 32'd5);
      check("add_alu_data2", alu_data2_o, 32'd7);
      check("add_alu_ctrl", 32'(alu_ctrl_o), 32'd3);
      check("add_busy", 32'(busy_o), 32'd1);
      check("add_ready_exec", 32'(req0_ready_o), 32'd0);
      @(negedge clk_i);
      check("add_resp_valid", 32'(resp0_valid_o), 32'd1);
      @(negedge clk_i);
      check("add_idle", 32'(busy_o), 32'd0);
      check("add_resp_dropped", 32'(resp0_valid_o), 32'd0);
      check("add_data_retained", resp0_data_o, 32'd12);
      check("add_alu_retained", alu_data1_o, 32'd5);

      // Contention held continuously: grants 0,1,0,1 after reset
      do_reset();
      set_req(1'b0, 1'b1, 3'b100, 32'd10, 32'd3);
      set_req(1'b1, 1'b1, 3'b010, 32'h0000_00F0, 32'h0000_00FF);
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (req0_ready_o || req1_ready_o) begin
               seen = 1'b1;
               break;
            end
         end
         check("arb_ready_seen", 32'(seen), 32'd1);
         check("arb_grant_order", 32'(req1_ready_o), 32'(k % 2));
         check("arb_grant_onehot", 32'(req0_ready_o & req1_ready_o), 32'd0);
         @(posedge clk_i);
         if (k % 2 == 0) sb_q.push_back('{id: 1'b0, data: 32'd7});
         else            sb_q.push_back('{id: 1'b1, data: 32'h0000_000F});
      end
      #1;
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      wait_idle(20);

      // Multiply on requester 1: operands stable T+1..T+3, response at T+4
      issue(1'b1, 3'b101, 32'd6, 32'hFFFF_FFF9, 1'b1);
      for (int j = 1; j <= 3; j++) begin
         @(negedge clk_i);
         check("mul_alu_data1", alu_data1_o, 32'd6);
         check("mul_alu_data2", alu_data2_o, 32'hFFFF_FFF9);
         check("mul_alu_ctrl", 32'(alu_ctrl_o), 32'd5);
         check("mul_resp_early", 32'(resp1_valid_o), 32'd0);
      end
      @(negedge clk_i);
      check("mul_resp_valid", 32'(resp1_valid_o), 32'd1);
      check("mul_resp_data", resp1_data_o, 32'hFFFF_FFD6);
      wait_idle(10);

      // Back-pressure on response 1
      resp1_ready_i = 1'b0;
      issue(1'b1, 3'b011, 32'd100, 32'd23, 1'b1);
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (resp1_valid_o) begin
            seen = 1'b1;
            break;
         end
      end
      check("hold_resp_seen", 32'(seen), 32'd1);
      set_req(1'b0, 1'b1, 3'b000, 32'hFF, 32'h0F);
      for (int j = 0; j < 5; j++) begin
         check("hold_valid", 32'(resp1_valid_o), 32'd1);
         check("hold_data", resp1_data_o, 32'd123);
         check("hold_ready", {30'd0, req1_ready_o, req0_ready_o}, 32'd0);
         check("hold_busy", 32'(busy_o), 32'd1);
         @(negedge clk_i);
      end
      @(posedge clk_i);
      #1 resp1_ready_i = 1'b1;
      @(negedge clk_i);
      check("release_no_accept", 32'(req0_ready_o), 32'd0);
      @(posedge clk_i);
      #1 req0_valid_i = 1'b0;
      @(negedge clk_i);
      check("release_idle", 32'(busy_o), 32'd0);
      check("release_resp_low", 32'(resp1_valid_o), 32'd0);
      @(negedge clk_i);
      check("dropped_req_ignored", 32'(busy_o), 32'd0);

      // Reset during a multiply aborts it; contention then goes to requester 0
      resp0_ready_i = 1'b1;
      issue(1'b0, 3'b101, 32'd3, 32'd4, 1'b0);
      @(negedge clk_i);
      check("abort_busy_exec", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk_i);
         check("abort_idle", 32'(busy_o), 32'd0);
         check("abort_no_resp", {30'd0, resp1_valid_o, resp0_valid_o}, 32'd0);
      end
      check("abort_alu_cleared", alu_data1_o, 32'd0);
      @(posedge clk_i);
      #1;
      set_req(1'b0, 1'b1, 3'b000, 32'hFF00, 32'h0FF0);
      set_req(1'b1, 1'b1, 3'b001, 32'h1, 32'h2);
      @(negedge clk_i);
      check("abort_grant0", {30'd0, req1_ready_o, req0_ready_o}, 32'd1);
      @(posedge clk_i);
      if (req0_ready_o) sb_q.push_back('{id: 1'b0, data: 32'h0000_0F00});
      #1;
      req0_valid_i = 1'b0;
      req1_valid_i = 1'b0;
      wait_idle(10);

      // Arithmetic shift right of a negative operand
      issue(1'b0, 3'b111, 32'h8000_0000, 32'd4, 1'b1);
      wait_idle(10);
      check("sra_data", resp0_data_o, 32'hF800_0000);

      repeat (2) @(negedge clk_i);
      check("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
